usb20sr_refdes_nios2_qsys_0_oci_dct_packer: RTL and testbench

Producer side of the OCI direct-capture trace (DCT) path. It packs 2-bit trace symbols from the debug core into a 30-bit buffer, slot 0 in the LSBs. It emits completed or flushed words through a single-entry valid/ready output register. It drives the dct_buffer/dct_count/test_ending/test_has_ended signals that the OCI test-bench monitor consumes, including an orderly end-of-test drain sequence.

---
 rtl/usb20sr_refdes_nios2_qsys_0_oci_dct_packer.sv | 141 ++++++++++++++
 tb/tb_usb20sr_refdes_nios2_qsys_0_oci_dct_packer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/usb20sr_refdes_nios2_qsys_0_oci_dct_packer.sv
// OCI direct-capture trace packer: packs 2-bit trace symbols into 30-bit words,
// hands them off through a one-entry valid/ready register, and sequences end-of-test.
module usb20sr_refdes_nios2_qsys_0_oci_dct_packer #(
  parameter int SYM_W  = 2,
  parameter int SLOTS  = 15,
  parameter int DROP_W = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     sym_valid,
  input  logic [SYM_W-1:0]         sym_data,
  input  logic                     flush,
  input  logic                     stop,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [SYM_W*SLOTS-1:0]   out_buffer,
  output logic [3:0]               out_count,
  output logic [SYM_W*SLOTS-1:0]   dct_buffer,
  output logic [3:0]               dct_count,
  output logic                     test_ending,
  output logic                     test_has_ended,
  output logic                     overflow,
  output logic [DROP_W-1:0]        drop_count
);

  localparam int BUF_W = SYM_W * SLOTS;

  typedef enum logic [1:0] {ST_RUN, ST_DRAIN, ST_ENDING, ST_ENDED} state_t;

  state_t              state_q, state_d;
  logic [BUF_W-1:0]    acc_q, acc_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                out_valid_q, out_valid_d;
  logic [BUF_W-1:0]    out_buf_q, out_buf_d;
  logic [3:0]          out_cnt_q, out_cnt_d;
  logic                flush_pend_q, flush_pend_d;
  logic                overflow_q, overflow_d;
  logic [DROP_W-1:0]   drop_q, drop_d;

  logic                transfer, slot_free, sym_take, flush_run, flush_req;
  logic                full, append, complete, handoff;
  logic [BUF_W-1:0]    post_acc;
  logic [3:0]          post_cnt;

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    transfer  = out_valid_q && out_ready;
    slot_free = !out_valid_q || out_ready;
    sym_take  = sym_valid && (state_q == ST_RUN);
    flush_run = flush && (state_q == ST_RUN);
    flush_req = flush_run || flush_pend_q || (state_q == ST_DRAIN);
    full      = (cnt_q == 4'(SLOTS));
    append    = sym_take && !full;

    post_acc = acc_q;
    post_cnt = cnt_q;
    if (append) begin
      post_acc = acc_q | (BUF_W'(sym_data) << (SYM_W * cnt_q));
      post_cnt = cnt_q + 4'd1;
    end

    complete = (post_cnt == 4'(SLOTS)) || (flush_req && (post_cnt != 4'd0));
    handoff  = complete && slot_free;

    acc_d        = post_acc;
    cnt_d        = post_cnt;
    out_valid_d  = out_valid_q;
    out_buf_d    = out_buf_q;
    out_cnt_d    = out_cnt_q;
    flush_pend_d = flush_pend_q;
    overflow_d   = overflow_q;
    drop_d       = drop_q;

    if (handoff) begin
      out_buf_d    = post_acc;
      out_cnt_d    = post_cnt;
      out_valid_d  = 1'b1;
      flush_pend_d = 1'b0;
      acc_d        = '0;
      cnt_d        = 4'd0;
      // A symbol arriving on a full-word handoff starts the next word.
      if (sym_take && full) begin
        acc_d = BUF_W'(sym_data);
        cnt_d = 4'd1;
      end
    end else begin
      if (transfer) out_valid_d = 1'b0;
      if (flush_run && (post_cnt != 4'd0)) flush_pend_d = 1'b1;
      if (sym_take && full) begin
        overflow_d = 1'b1;
        drop_d     = sat_inc(drop_q);
      end
    end

    state_d = state_q;
    case (state_q)
      ST_RUN:    if (stop) state_d = ST_DRAIN;
      ST_DRAIN:  if ((cnt_q == 4'd0) && !out_valid_q) state_d = ST_ENDING;
      ST_ENDING: state_d = ST_ENDED;
      default:   state_d = ST_ENDED;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_RUN;
      acc_q        <= '0;
      cnt_q        <= '0;
      out_valid_q  <= 1'b0;
      out_buf_q    <= '0;
      out_cnt_q    <= '0;
      flush_pend_q <= 1'b0;
      overflow_q   <= 1'b0;
      drop_q       <= '0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      out_valid_q  <= out_valid_d;
      out_buf_q    <= out_buf_d;
      out_cnt_q    <= out_cnt_d;
      flush_pend_q <= flush_pend_d;
      overflow_q   <= overflow_d;
      drop_q       <= drop_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign out_buffer     = out_buf_q;
  assign out_count      = out_cnt_q;
  assign dct_buffer     = acc_q;
  assign dct_count      = cnt_q;
  assign test_ending    = (state_q == ST_ENDING);
  assign test_has_ended = (state_q == ST_ENDED);
  assign overflow       = overflow_q;
  assign drop_count     = drop_q;

endmodule

// File: tb/tb_usb20sr_refdes_nios2_qsys_0_oci_dct_packer.sv
// Bench for the DCT packer: directed vector table, hand sequences for
// back-pressure/drain/reset, and randomized traffic against a queue-based model.
module tb_usb20sr_refdes_nios2_qsys_0_oci_dct_packer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        sym_valid, flush, stop, out_ready;
  logic [1:0]  sym_data;
  logic        out_valid, test_ending, test_has_ended, overflow;
  logic [29:0] out_buffer, dct_buffer;
  logic [3:0]  out_count, dct_count;
  logic [7:0]  drop_count;

  int checks = 0;
  int errors = 0;

  usb20sr_refdes_nios2_qsys_0_oci_dct_packer dut (
    .clk(clk), .reset_n(reset_n), .sym_valid(sym_valid), .sym_data(sym_data),
    .flush(flush), .stop(stop), .out_ready(out_ready), .out_valid(out_valid),
    .out_buffer(out_buffer), .out_count(out_count), .dct_buffer(dct_buffer),
    .dct_count(dct_count), .test_ending(test_ending), .test_has_ended(test_has_ended),
    .overflow(overflow), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  // Reference model: accumulator is a queue of symbols, word value built by arithmetic.
  int          mq[$];
  bit          m_ov, m_ovf, m_fpend;
  logic [29:0] m_obuf;
  int          m_ocnt, m_drop, m_phase;

  function automatic logic [29:0] mpack();
    logic [29:0] w = '0;
    foreach (mq[i]) w = w | (30'(mq[i]) << (2 * i));
    return w;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_ov = 0; m_ovf = 0; m_fpend = 0; m_obuf = '0;
    m_ocnt = 0; m_drop = 0; m_phase = 0;
  endtask

  task automatic model_step(bit sv, int sd, bit fl, bit st, bit rdy);
    bit xfer, free, run, take, freq, complete, pre_ov;
    int pre_n;
    pre_n = mq.size(); pre_ov = m_ov;
    xfer = m_ov && rdy;
    free = !m_ov || rdy;
    run  = (m_phase == 0);
    take = sv && run;
    freq = (fl && run) || m_fpend || (m_phase == 1);
    if (take && mq.size() < 15) begin mq.push_back(sd); take = 0; end
    complete = (mq.size() == 15) || (freq && mq.size() > 0);
    if (complete && free) begin
      m_obuf = mpack(); m_ocnt = mq.size(); m_ov = 1; mq.delete(); m_fpend = 0;
      if (take) begin mq.push_back(sd); take = 0; end
    end else begin
      if (xfer) m_ov = 0;
      if (fl && run && mq.size() > 0) m_fpend = 1;
    end
    if (take) begin m_ovf = 1; if (m_drop < 255) m_drop++; end
    case (m_phase)
      0: if (st) m_phase = 1;
      1: if (pre_n == 0 && !pre_ov) m_phase = 2;
      2: m_phase = 3;
      default: ;
    endcase
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(bit sv, logic [1:0] sd, bit fl, bit st, bit rdy);
    sym_valid = sv; sym_data = sd; flush = fl; stop = st; out_ready = rdy;
    model_step(sv, int'(sd), fl, st, rdy);
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; sym_valid = 0; sym_data = 0; flush = 0; stop = 0; out_ready = 0;
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    model_reset();
  endtask

  task automatic cmp_model();
    chk("rnd_dct_count", 32'(dct_count), 32'(mq.size()));
    chk("rnd_dct_buffer", 32'(dct_buffer), 32'(mpack()));
    chk("rnd_out_valid", 32'(out_valid), 32'(m_ov));
    chk("rnd_out_word", {out_count, out_buffer[27:0]}, {4'(m_ocnt), m_obuf[27:0]});
    chk("rnd_flags", {out_buffer[29:28], overflow, test_ending, test_has_ended},
        {m_obuf[29:28], m_ovf, m_phase == 2, m_phase == 3});
    chk("rnd_drop_count", 32'(drop_count), 32'(m_drop));
  endtask

  typedef struct {
    bit          sv;
    logic [1:0]  sd;
    bit          fl;
    bit          rdy;
    bit          e_ov;
    logic [3:0]  e_oc;
    logic [29:0] e_ob;
    logic [3:0]  e_dc;
    logic [29:0] e_db;
  } vec_t;

  vec_t tbl[10];

  initial begin
    logic [29:0] w1, w2;
    int ending_cycles, word_cnt;
    bit ended;

    tbl[0] = '{1, 2'b11, 0, 1, 0, 4'd0, 30'h0,  4'd1, 30'h3};
    tbl[1] = '{1, 2'b11, 0, 1, 0, 4'd0, 30'h0,  4'd2, 30'hF};
    tbl[2] = '{1, 2'b11, 0, 1, 0, 4'd0, 30'h0,  4'd3, 30'h3F};
    tbl[3] = '{0, 2'b00, 1, 1, 1, 4'd3, 30'h3F, 4'd0, 30'h0};
    tbl[4] = '{0, 2'b00, 1, 1, 0, 4'd3, 30'h3F, 4'd0, 30'h0};
    tbl[5] = '{0, 2'b00, 0, 1, 0, 4'd3, 30'h3F, 4'd0, 30'h0};
    tbl[6] = '{1, 2'b01, 0, 1, 0, 4'd3, 30'h3F, 4'd1, 30'h1};
    tbl[7] = '{1, 2'b00, 0, 1, 0, 4'd3, 30'h3F, 4'd2, 30'h1};
    tbl[8] = '{1, 2'b10, 1, 1, 1, 4'd3, 30'h21, 4'd0, 30'h0};
    tbl[9] = '{0, 2'b00, 0, 1, 0, 4'd3, 30'h21, 4'd0, 30'h0};

    do_reset();
    chk("reset_outputs", {out_valid, out_count, dct_count, test_ending, test_has_ended, overflow, drop_count},
        32'h0);
    chk("reset_buffers", out_buffer | dct_buffer, 32'h0);

    // Directed table: flush of a partial word, empty flush, flush with same-cycle symbol.
    for (int i = 0; i < 10; i++) begin
      step(tbl[i].sv, tbl[i].sd, tbl[i].fl, 0, tbl[i].rdy);
      chk($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
      chk($sformatf("tbl%0d_out_count", i), 32'(out_count), 32'(tbl[i].e_oc));
      chk($sformatf("tbl%0d_out_buffer", i), 32'(out_buffer), 32'(tbl[i].e_ob));
      chk($sformatf("tbl%0d_dct_count", i), 32'(dct_count), 32'(tbl[i].e_dc));
      chk($sformatf("tbl%0d_dct_buffer", i), 32'(dct_buffer), 32'(tbl[i].e_db));
    end

    // Full word of alternating 01/10.
    do_reset();
    for (int i = 0; i < 15; i++) begin
      step(1, (i % 2 == 0) ? 2'b01 : 2'b10, 0, 0, 1);
      if (i == 13) chk("t1_valid_before_last", 32'(out_valid), 32'd0);
    end
    chk("t1_out_valid", 32'(out_valid), 32'd1);
    chk("t1_out_buffer", 32'(out_buffer), 32'h19999999);
    chk("t1_out_count", 32'(out_count), 32'd15);
    chk("t1_dct_count", 32'(dct_count), 32'd0);

    // Back-pressure: one word held, one full in the accumulator, five drops.
    do_reset();
    w1 = '0; w2 = '0;
    for (int i = 0; i < 15; i++) w1 = w1 | (30'(i % 4) << (2 * i));
    for (int i = 0; i < 15; i++) w2 = w2 | (30'(3 - (i % 4)) << (2 * i));
    for (int i = 0; i < 15; i++) step(1, 2'(i % 4), 0, 0, 0);
    for (int i = 0; i < 15; i++) step(1, 2'(3 - (i % 4)), 0, 0, 0);
    chk("t3_dct_full", 32'(dct_count), 32'd15);
    for (int i = 0; i < 5; i++) step(1, 2'b01, 0, 0, 0);
    chk("t3_drop_count", 32'(drop_count), 32'd5);
    chk("t3_overflow", 32'(overflow), 32'd1);
    chk("t3_word1", 32'(out_buffer), 32'(w1));
    step(0, 0, 0, 0, 1);
    chk("t3_b2b_valid", 32'(out_valid), 32'd1);
    chk("t3_word2", {out_count, out_buffer}, {4'd15, w2});
    chk("t3_dct_after", 32'(dct_count), 32'd0);
    step(0, 0, 0, 0, 1);
    chk("t3_drained", 32'(out_valid), 32'd0);
    chk("t3_overflow_sticky", 32'(overflow), 32'd1);

    // Drop counter saturation.
    do_reset();
    for (int i = 0; i < 290; i++) step(1, 2'b10, 0, 0, 0);
    chk("sat_drop_count", 32'(drop_count), 32'd255);

    // Stop: drain a 4-symbol word, single test_ending pulse, then ended.
    do_reset();
    for (int i = 0; i < 4; i++) step(1, 2'b11, 0, 0, 1);
    step(0, 0, 0, 1, 1);
    ending_cycles = 0; word_cnt = 0; ended = 0;
    for (int i = 0; i < 20 && !ended; i++) begin
      step(0, 0, 0, 0, 1);
      if (out_valid && word_cnt == 0) word_cnt = int'(out_count);
      if (test_ending) ending_cycles++;
      if (test_has_ended) ended = 1;
    end
    chk("t5_drain_word_count", 32'(word_cnt), 32'd4);
    chk("t5_ending_pulse", 32'(ending_cycles), 32'd1);
    chk("t5_has_ended", 32'(ended), 32'd1);
    for (int i = 0; i < 5; i++) step(1, 2'b01, (i == 2), (i == 3), 1);
    chk("t5_ignored_syms", {dct_count, drop_count, out_valid}, 32'h0);
    chk("t5_still_ended", {test_has_ended, test_ending}, 32'd2);

    // Asynchronous reset mid-word.
    do_reset();
    for (int i = 0; i < 22; i++) step(1, 2'b11, 0, 0, 0);
    chk("t6_pre_state", {out_valid, dct_count}, {1'b1, 4'd7});
    #2 reset_n = 1'b0;
    #1;
    chk("t6_async_zero", {out_valid, out_count, dct_count, overflow, drop_count, test_has_ended},
        32'h0);
    chk("t6_async_bufs", out_buffer | dct_buffer, 32'h0);
    @(posedge clk); #1 reset_n = 1'b1;
    model_reset();
    step(1, 2'b10, 0, 0, 1);
    chk("t6_first_slot0", {dct_count, dct_buffer}, {4'd1, 30'h2});

    // Randomized traffic compared each cycle to the model.
    for (int r = 0; r < 3; r++) begin
      do_reset();
      for (int c = 0; c < 600; c++) begin
        bit rdy;
        case (r)
          0: rdy = ($urandom_range(0, 3) != 0);
          1: rdy = ($urandom_range(0, 15) == 0);
          default: rdy = $urandom_range(0, 1) != 0;
        endcase
        step($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), $urandom_range(0, 15) == 0,
             (r == 2) && ($urandom_range(0, 299) == 0), rdy);
        cmp_model();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
